mor1kx_icache_refill: RTL
=========================

MOR1KX_ICACHE_REFILL -- requirements
Module: mor1kx_icache_refill

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter OPTION_ICACHE_BLOCK_WIDTH, default 5, log2 line bytes; legal values 4 or 5 (4 or 8 words/line).
REQ-003 SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port refill_req_i, input, 1, cache miss refill request.
REQ-006 SHALL have port refill_adr_i, input, 32, missing fetch address.
REQ-007 SHALL have port wradr_o, output, 32, line-write word address to cache.
REQ-008 SHALL have port wrdat_o, output, 32, line-write data to cache.
REQ-009 SHALL have port we_o, output, 1, line-write strobe to cache.
REQ-010 SHALL have port ic_imem_err_o, output, 1, bus error pulse to cache.
REQ-011 SHALL have ports ibus_req_o (out, 1), ibus_adr_o (out, 32), ibus_burst_o (out, 1), ibus_dat_i (in, 32), ibus_ack_i (in, 1), ibus_err_i (in, 1): instruction bus master.
REQ-012 SHALL have port busy_o, output, 1, high in any state except IDLE.

Function
REQ-013 SHALL implement states IDLE, BURST, DONE.
REQ-014 IDLE: refill_req_i high -> latch refill_adr_i[31:2], word counter = 0, enter BURST next cycle.
REQ-015 BURST: ibus_req_o = 1, ibus_adr_o = current word address (bits [1:0] = 0).
REQ-016 Each ibus_ack_i: counter +1, word address +4 wrapping inside the line (upper bits fixed).
REQ-017 ibus_burst_o SHALL be high in BURST except while counter = last word index.
REQ-018 Ack in cycle N -> we_o = 1 in cycle N+1, wradr_o = acked address, wrdat_o = ibus_dat_i sampled in cycle N.
REQ-019 Ack on last word -> ibus_req_o low next cycle, enter DONE; exactly 2^(BLOCK_WIDTH-2) we_o pulses per refill.
REQ-020 DONE: return to IDLE when refill_req_i low; new request accepted only from IDLE.
REQ-021 ibus_err_i in BURST (priority over simultaneous ack) -> no we_o for that beat, ic_imem_err_o = 1 for one cycle, ibus_req_o low, enter IDLE.
REQ-022 refill_req_i dropping during BURST SHALL NOT abort the burst.
REQ-023 ibus_ack_i/ibus_err_i outside BURST SHALL be ignored.

Reset
REQ-024 rst -> state IDLE, ibus_req_o/ibus_burst_o/we_o/ic_imem_err_o/busy_o = 0, ibus_adr_o/wradr_o/wrdat_o = 0, counter = 0.
REQ-025 rst mid-burst -> ibus_req_o low in the following cycle; no further we_o.

Configuration
REQ-026 Macro MOR1KX_ICACHE_REFILL_CWF_EN defined: burst starts at the missing word (critical word first), wrapping.
REQ-027 Macro undefined: burst starts at line base (refill_adr_i[BLOCK_WIDTH-1:0] forced 0), linear order.

Structure
REQ-028 State encoding typedef and line-word-count constant SHALL live in shared package mor1kx_icache_pkg.
REQ-029 Wrap-increment address logic SHALL be sub-module mor1kx_icache_refill_adrgen.
REQ-030 No further sub-modules; single always_ff for state, counter, outputs.

Verification
REQ-031 CWF_EN, BLOCK_WIDTH=5, miss 0x0000_1014, ack every cycle -> ibus_adr 0x14,0x18,0x1C,0x00..0x10 (base 0x1000); 8 we_o; burst low on 8th.
REQ-032 Macro off, same miss -> addresses 0x1000..0x101C linear; 8 we_o; wrdat_o matches bus data one cycle later.
REQ-033 ibus_err_i on 3rd beat -> 2 we_o total, ic_imem_err_o one-cycle pulse, state IDLE, ibus_req_o low next cycle.
REQ-034 rst asserted on 4th beat -> all outputs 0 next cycle; next refill_req_i starts fresh at counter 0.
REQ-035 BLOCK_WIDTH=4, ack with 2-cycle gaps, refill_req_i held through DONE -> 4 we_o, stays DONE until refill_req_i low, then IDLE.

Source files
------------

// File: rtl/mor1kx_icache_pkg.sv
// Shared definitions for the instruction-cache refill logic.
//   refill_state_t   : refill FSM state encoding
//   ICACHE_BW_DEFAULT / ICACHE_LINE_WORDS : default line geometry
//   line_words()     : words per line for a given log2(line bytes)
package mor1kx_icache_pkg;

  typedef enum logic [1:0] {
    REFILL_IDLE  = 2'd0,
    REFILL_BURST = 2'd1,
    REFILL_DONE  = 2'd2
  } refill_state_t;

  localparam int ICACHE_BW_DEFAULT = 5;
  localparam int ICACHE_LINE_WORDS = 1 << (ICACHE_BW_DEFAULT - 2);

  function automatic int line_words(input int block_width);
    return 1 << (block_width - 2);
  endfunction

endpackage

// File: rtl/mor1kx_icache_refill_adrgen.sv
// Next-word address generator for a cache line refill.
// Increments the word index inside the line and wraps at the line end;
// bits above the line offset and the byte offset pass through unchanged.
//   adr_i      : current word address (byte address, bits [1:0] = 0)
//   adr_next_o : following word address within the same line
module mor1kx_icache_refill_adrgen
  import mor1kx_icache_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = ICACHE_BW_DEFAULT
) (
  input  logic [OPTION_OPERAND_WIDTH-1:0] adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] adr_next_o
);

  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;

  logic [BW-3:0] word_next;

  assign word_next  = adr_i[BW-1:2] + {{(BW-3){1'b0}}, 1'b1};
  assign adr_next_o = {adr_i[OPTION_OPERAND_WIDTH-1:BW], word_next, adr_i[1:0]};

endmodule

// File: rtl/mor1kx_icache_refill.sv
// Instruction-cache line refill controller.
// On a miss request it bursts one cache line over the instruction bus and
// streams each acknowledged word into the cache one cycle later.
// Optional feature macro: MOR1KX_ICACHE_REFILL_CWF_EN -- when defined the
// burst starts at the missing word (critical word first, wrapping);
// otherwise it starts at the line base and runs linearly.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   refill_req_i/adr_i      : miss request and missing fetch address
//   wradr_o/wrdat_o/we_o    : line-write port to the cache
//   ic_imem_err_o           : one-cycle bus error pulse to the cache
//   ibus_*                  : instruction bus master
//   busy_o                  : high whenever the FSM is not idle
//
// state        | meaning
// REFILL_IDLE  | waiting for a miss request
// REFILL_BURST | bus burst in progress, one word per ack
// REFILL_DONE  | line written, waiting for refill_req_i to drop
module mor1kx_icache_refill
  import mor1kx_icache_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = ICACHE_BW_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            ic_imem_err_o,
  output logic                            ibus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_burst_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  output logic                            busy_o
);

  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int CW = BW - 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(line_words(BW) - 1);

  refill_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [OW-1:0] adr_q, adr_d, adr_next, start_adr;
  logic [OW-1:0] wradr_q, wradr_d;
  logic [OW-1:0] wrdat_q, wrdat_d;
  logic          ireq_q, ireq_d;
  logic          burst_q, burst_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  mor1kx_icache_refill_adrgen #(
    .OPTION_OPERAND_WIDTH     (OW),
    .OPTION_ICACHE_BLOCK_WIDTH(BW)
  ) u_adrgen (
    .adr_i     (adr_q),
    .adr_next_o(adr_next)
  );

  assign cnt_inc = cnt_q + {{(CW-1){1'b0}}, 1'b1};

  always_comb begin
    start_adr = refill_adr_i;
`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
    start_adr[1:0] = 2'b00;
`else
    start_adr[BW-1:0] = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    ireq_d  = ireq_q;
    burst_d = burst_q;
    we_d    = 1'b0;
    wradr_d = wradr_q;
    wrdat_d = wrdat_q;
    err_d   = 1'b0;
    case (state_q)
      REFILL_IDLE: begin
        if (refill_req_i) begin
          state_d = REFILL_BURST;
          cnt_d   = '0;
          adr_d   = start_adr;
          ireq_d  = 1'b1;
          burst_d = 1'b1;
        end
      end
      REFILL_BURST: begin
        // An error wins over a simultaneous ack: the beat is dropped.
        if (ibus_err_i) begin
          state_d = REFILL_IDLE;
          ireq_d  = 1'b0;
          burst_d = 1'b0;
          err_d   = 1'b1;
        end else if (ibus_ack_i) begin
          we_d    = 1'b1;
          wradr_d = adr_q;
          wrdat_d = ibus_dat_i;
          if (cnt_q == LAST_IDX) begin
            state_d = REFILL_DONE;
            ireq_d  = 1'b0;
            burst_d = 1'b0;
          end else begin
            cnt_d   = cnt_inc;
            adr_d   = adr_next;
            // Burst flag drops while the last word is outstanding.
            burst_d = (cnt_inc != LAST_IDX);
          end
        end
      end
      REFILL_DONE: begin
        if (!refill_req_i) state_d = REFILL_IDLE;
      end
      default: state_d = REFILL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REFILL_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      ireq_q  <= 1'b0;
      burst_q <= 1'b0;
      we_q    <= 1'b0;
      wradr_q <= '0;
      wrdat_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      ireq_q  <= ireq_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      wradr_q <= wradr_d;
      wrdat_q <= wrdat_d;
      err_q   <= err_d;
    end
  end

  assign ibus_req_o    = ireq_q;
  assign ibus_adr_o    = adr_q;
  assign ibus_burst_o  = burst_q;
  assign we_o          = we_q;
  assign wradr_o       = wradr_q;
  assign wrdat_o       = wrdat_q;
  assign ic_imem_err_o = err_q;
  assign busy_o        = (state_q != REFILL_IDLE);

endmodule
